// File: rtl/floor_capacity_tracker.sv
// Per-floor free-space counters for the parking lot plus the timed entry/exit gate.
// Each enter/exit event moves exactly one counter by one and (re)opens the gate.
module floor_capacity_tracker #(
    parameter int CNT_W       = 3,
    parameter int CAP_SPEC_0  = 2,
    parameter int CAP_NORM_0  = 5,
    parameter int CAP_FLR_1   = 7,
    parameter int GATE_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       MODE,
    input  logic [2:0]       action_taken,
    input  logic             chosen_flr,
    input  logic             id_special,
    input  logic             id_valid,
    input  logic             user_in_floor,
    output logic [CNT_W-1:0] remain_flr_spec_0,
    output logic [CNT_W-1:0] remain_flr_norm_0,
    output logic [CNT_W-1:0] remain_flr_1,
    output logic             lot_full,
    output logic             gate_open,
    output logic             ovf_err,
    output logic             unf_err
);
    localparam int GC_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CAP_S  = CNT_W'(CAP_SPEC_0);
    localparam logic [CNT_W-1:0] CAP_N  = CNT_W'(CAP_NORM_0);
    localparam logic [CNT_W-1:0] CAP_F  = CNT_W'(CAP_FLR_1);
    localparam logic [GC_W-1:0]  GC_MAX = GC_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {G_IDLE, G_OPEN, G_CLOSING} gate_st_e;
    typedef enum logic [1:0] {A_SPEC0, A_NORM0, A_FLR1} area_e;

    logic [2:0]       prev_act_q;
    logic [CNT_W-1:0] spec_q, spec_d, norm_q, norm_d, flr1_q, flr1_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    gate_st_e         gst_q, gst_d;
    logic [GC_W-1:0]  gcnt_q, gcnt_d;

    logic             evt, id_ok, is_entry, is_exit, floor_sel, counted;
    area_e            area;
    logic [CNT_W-1:0] cur, cap;

    always_comb begin
        evt      = (action_taken != prev_act_q) &&
                   (action_taken == 3'd1 || action_taken == 3'd2 || action_taken == 3'd3);
        id_ok    = id_valid || id_special;
        is_entry = evt && (action_taken != 3'd3) && (MODE == 2'd0) && id_ok;
        is_exit  = evt && (action_taken == 3'd3) && (MODE == 2'd1) && id_ok;

        // Action 1 means the user was redirected to the floor they did not ask for.
        floor_sel = is_exit ? user_in_floor
                            : ((action_taken == 3'd2) ? chosen_flr : ~chosen_flr);
        if (id_special)     area = A_SPEC0;
        else if (floor_sel) area = A_FLR1;
        else                area = A_NORM0;

        case (area)
            A_SPEC0: begin cur = spec_q; cap = CAP_S; end
            A_NORM0: begin cur = norm_q; cap = CAP_N; end
            default: begin cur = flr1_q; cap = CAP_F; end
        endcase

        ovf_d   = is_entry && (cur == '0);
        unf_d   = is_exit  && (cur == cap);
        counted = (is_entry && !ovf_d) || (is_exit && !unf_d);

        spec_d = spec_q;
        norm_d = norm_q;
        flr1_d = flr1_q;
        if (counted) begin
            case (area)
                A_SPEC0: spec_d = is_entry ? spec_q - 1'b1 : spec_q + 1'b1;
                A_NORM0: norm_d = is_entry ? norm_q - 1'b1 : norm_q + 1'b1;
                default: flr1_d = is_entry ? flr1_q - 1'b1 : flr1_q + 1'b1;
            endcase
        end
    end

    always_comb begin
        gst_d  = gst_q;
        gcnt_d = gcnt_q;
        case (gst_q)
            G_IDLE: if (counted) begin
                gst_d  = G_OPEN;
                gcnt_d = GC_MAX;
            end
            G_OPEN: begin
                if (counted)              gcnt_d = GC_MAX;
                else if (gcnt_q == '0)    gst_d  = G_CLOSING;
                else                      gcnt_d = gcnt_q - 1'b1;
            end
            G_CLOSING: begin
                gst_d = G_IDLE;
                if (counted) begin
                    gst_d  = G_OPEN;
                    gcnt_d = GC_MAX;
                end
            end
            default: gst_d = G_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_act_q <= '0;
            spec_q     <= CAP_S;
            norm_q     <= CAP_N;
            flr1_q     <= CAP_F;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            gst_q      <= G_IDLE;
            gcnt_q     <= '0;
        end else begin
            prev_act_q <= action_taken;
            spec_q     <= spec_d;
            norm_q     <= norm_d;
            flr1_q     <= flr1_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            gst_q      <= gst_d;
            gcnt_q     <= gcnt_d;
        end
    end

    assign remain_flr_spec_0 = spec_q;
    assign remain_flr_norm_0 = norm_q;
    assign remain_flr_1      = flr1_q;
    assign lot_full          = (norm_q == '0) && (flr1_q == '0);
    assign gate_open         = (gst_q == G_OPEN);
    assign ovf_err           = ovf_q;
    assign unf_err           = unf_q;
endmodule
